// File: rtl/decode_stage_reg.sv
// Decode stage for the pipelined RV32 core: register file with write-first
// bypass from writeback, main control decode, immediate extension, load-use
// hazard detection and the registered ID/EX boundary (valid, stall, flush).

// Main control decoder: opcode/funct fields to datapath control.
module control_unit (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic       reg_write,
    output logic       mem_write,
    output logic       jump,
    output logic       branch,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       adder_src,
    output logic [1:0] res_src,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src
);
    // Opcode decode; unknown opcodes fall back to an all-zero (no side effect) control word.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        adder_src   = 1'b0;
        res_src     = 2'b00;
        alu_control = 4'b0000;
        imm_src     = 3'd0;
        case (opcode)
            7'b0110011: begin   // R-type ALU
                reg_write   = 1'b1;
                alu_control = {funct7_5, funct3};
            end
            7'b0010011: begin   // I-type ALU; funct7 bit only matters for SRAI
                reg_write   = 1'b1;
                alu_src_b   = 1'b1;
                alu_control = {(funct3 == 3'b101) & funct7_5, funct3};
            end
            7'b0000011: begin   // load
                reg_write = 1'b1;
                alu_src_b = 1'b1;
                res_src   = 2'b01;
            end
            7'b0100011: begin   // store
                mem_write = 1'b1;
                alu_src_b = 1'b1;
                imm_src   = 3'd1;
            end
            7'b1100011: begin   // branch: compare by subtraction
                branch      = 1'b1;
                alu_control = 4'b1000;
                imm_src     = 3'd2;
            end
            7'b1101111: begin   // jal: target from PC
                jump      = 1'b1;
                reg_write = 1'b1;
                res_src   = 2'b10;
                imm_src   = 3'd3;
            end
            7'b1100111: begin   // jalr: target from rs1
                jump      = 1'b1;
                reg_write = 1'b1;
                res_src   = 2'b10;
                alu_src_b = 1'b1;
                adder_src = 1'b1;
            end
            7'b0110111: begin   // lui: immediate passes straight to result
                reg_write = 1'b1;
                res_src   = 2'b11;
                imm_src   = 3'd4;
            end
            7'b0010111: begin   // auipc: PC + immediate
                reg_write = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
                imm_src   = 3'd4;
            end
            default: begin
                reg_write = 1'b0;
            end
        endcase
    end
endmodule

// Immediate extension for the I/S/B/J/U formats.
module imm_ext #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [31:7]           instr,
    input  logic [2:0]            imm_src,
    output logic [DATA_WIDTH-1:0] imm_val
);
    logic [31:0] imm32_s;

    // Reassemble the format-specific immediate and sign-extend to DATA_WIDTH.
    always_comb begin
        imm32_s = 32'd0;
        case (imm_src)
            3'd0:    imm32_s = {{20{instr[31]}}, instr[31:20]};
            3'd1:    imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'd2:    imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'd3:    imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            3'd4:    imm32_s = {instr[31:12], 12'd0};
            default: imm32_s = 32'd0;
        endcase
        imm_val = DATA_WIDTH'($signed(imm32_s));
    end
endmodule

module decode_stage_reg #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_COUNT     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_f,
    input  logic [DATA_WIDTH-1:0]    instr_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    input  logic                     reg_write_w,
    input  logic [4:0]               rd_w,
    input  logic [DATA_WIDTH-1:0]    result_w,
    input  logic                     flush_e,
    output logic                     stall_fd,
    output logic                     valid_e,
    output logic                     illegal_e,
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic                     jump_e,
    output logic                     branch_e,
    output logic                     alu_src_a_e,
    output logic                     alu_src_b_e,
    output logic                     adder_src_e,
    output logic [1:0]               res_src_e,
    output logic [3:0]               alu_control_e,
    output logic [2:0]               funct3_e,
    output logic [DATA_WIDTH-1:0]    rd1_e,
    output logic [DATA_WIDTH-1:0]    rd2_e,
    output logic [DATA_WIDTH-1:0]    imm_val_e,
    output logic [ADDRESS_WIDTH-1:0] pc_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [4:0]               rs1_e,
    output logic [4:0]               rs2_e,
    output logic [4:0]               rd_e
);
    localparam int         IDX_W     = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);
    localparam logic       IS_RV32E  = (REG_COUNT == 16);

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
    logic [4:0]            rs1_s, rs2_s, rd_s;
    logic [DATA_WIDTH-1:0] rd1_s, rd2_s, imm_s;
    logic                  wr_en_s, hazard_s, issue_s, illegal_s;
    logic                  reg_write_s, mem_write_s, jump_s, branch_s;
    logic                  alu_src_a_s, alu_src_b_s, adder_src_s;
    logic [1:0]            res_src_s;
    logic [3:0]            alu_control_s;
    logic [2:0]            imm_src_s;

    assign rs1_s = instr_f[19:15];
    assign rs2_s = instr_f[24:20];
    assign rd_s  = instr_f[11:7];

    // Writes to x0 and to indices outside the implemented file are dropped; the bypass obeys the same rule.
    assign wr_en_s = reg_write_w & (rd_w != 5'd0) & ({1'b0, rd_w} < REG_LIMIT);

    // RV32E only implements x0..x15, so any field with bit 4 set names a missing register.
    assign illegal_s = IS_RV32E & valid_f & (rs1_s[4] | rs2_s[4] | rd_s[4]);

    assign hazard_s = valid_e & (res_src_e == 2'b01) & (rd_e != 5'd0) & valid_f &
                      ((rd_e == rs1_s) | (rd_e == rs2_s));
    assign stall_fd = hazard_s & ~flush_e;
    assign issue_s  = valid_f & ~flush_e & ~stall_fd;

    control_unit u_control_unit (
        .opcode      (instr_f[6:0]),
        .funct3      (instr_f[14:12]),
        .funct7_5    (instr_f[30]),
        .reg_write   (reg_write_s),
        .mem_write   (mem_write_s),
        .jump        (jump_s),
        .branch      (branch_s),
        .alu_src_a   (alu_src_a_s),
        .alu_src_b   (alu_src_b_s),
        .adder_src   (adder_src_s),
        .res_src     (res_src_s),
        .alu_control (alu_control_s),
        .imm_src     (imm_src_s)
    );

    imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
        .instr   (instr_f[31:7]),
        .imm_src (imm_src_s),
        .imm_val (imm_s)
    );

    // Register file storage: cleared on reset, written by the writeback port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[rd_w[IDX_W-1:0]] <= result_w;
        end
    end

    // Operand read for rs1: x0/unimplemented read zero, a same-cycle writeback wins over storage.
    always_comb begin
        rd1_s = '0;
        if ((rs1_s == 5'd0) || ({1'b0, rs1_s} >= REG_LIMIT)) begin
            rd1_s = '0;
        end else if (wr_en_s && (rd_w == rs1_s)) begin
            rd1_s = result_w;
        end else begin
            rd1_s = regs_r[rs1_s[IDX_W-1:0]];
        end
    end

    // Operand read for rs2 with the same zero and bypass rules as rs1.
    always_comb begin
        rd2_s = '0;
        if ((rs2_s == 5'd0) || ({1'b0, rs2_s} >= REG_LIMIT)) begin
            rd2_s = '0;
        end else if (wr_en_s && (rd_w == rs2_s)) begin
            rd2_s = result_w;
        end else begin
            rd2_s = regs_r[rs2_s[IDX_W-1:0]];
        end
    end

    // ID/EX control: a flush, a stall or an empty fetch slot all load a bubble with no side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e       <= 1'b0;
            illegal_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            adder_src_e   <= 1'b0;
            res_src_e     <= 2'b00;
            alu_control_e <= 4'b0000;
        end else if (issue_s) begin
            valid_e       <= 1'b1;
            illegal_e     <= illegal_s;
            reg_write_e   <= reg_write_s;
            mem_write_e   <= mem_write_s;
            jump_e        <= jump_s;
            branch_e      <= branch_s;
            alu_src_a_e   <= alu_src_a_s;
            alu_src_b_e   <= alu_src_b_s;
            adder_src_e   <= adder_src_s;
            res_src_e     <= res_src_s;
            alu_control_e <= alu_control_s;
        end else begin
            valid_e       <= 1'b0;
            illegal_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            adder_src_e   <= 1'b0;
            res_src_e     <= 2'b00;
            alu_control_e <= 4'b0000;
        end
    end

    // ID/EX data: loaded every cycle; meaningless while valid_e is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_e   <= 3'd0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_val_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            rd_e       <= 5'd0;
        end else begin
            funct3_e   <= instr_f[14:12];
            rd1_e      <= rd1_s;
            rd2_e      <= rd2_s;
            imm_val_e  <= imm_s;
            pc_e       <= pc_f;
            pc_plus4_e <= pc_plus4_f;
            rs1_e      <= rs1_s;
            rs2_e      <= rs2_s;
            rd_e       <= rd_s;
        end
    end
endmodule

// File: tb/tb_decode_stage_reg.sv
// Bench for decode_stage_reg: an RV32I and an RV32E instance share the same
// stimulus and are checked against an instruction-level reference model.
module tb_decode_stage_reg;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_f, reg_write_w, flush_e;
    logic [31:0] instr_f, pc_f, pc_plus4_f, result_w;
    logic [4:0]  rd_w;

    logic        a_stall_fd, a_valid_e, a_illegal_e, a_reg_write_e, a_mem_write_e, a_jump_e, a_branch_e;
    logic        a_alu_src_a_e, a_alu_src_b_e, a_adder_src_e;
    logic [1:0]  a_res_src_e;
    logic [3:0]  a_alu_control_e;
    logic [2:0]  a_funct3_e;
    logic [31:0] a_rd1_e, a_rd2_e, a_imm_val_e, a_pc_e, a_pc_plus4_e;
    logic [4:0]  a_rs1_e, a_rs2_e, a_rd_e;

    logic        b_stall_fd, b_valid_e, b_illegal_e, b_reg_write_e, b_mem_write_e, b_jump_e, b_branch_e;
    logic        b_alu_src_a_e, b_alu_src_b_e, b_adder_src_e;
    logic [1:0]  b_res_src_e;
    logic [3:0]  b_alu_control_e;
    logic [2:0]  b_funct3_e;
    logic [31:0] b_rd1_e, b_rd2_e, b_imm_val_e, b_pc_e, b_pc_plus4_e;
    logic [4:0]  b_rs1_e, b_rs2_e, b_rd_e;

    always #5 clk = ~clk;

    decode_stage_reg #(.REG_COUNT(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f),
        .pc_plus4_f(pc_plus4_f), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .flush_e(flush_e), .stall_fd(a_stall_fd), .valid_e(a_valid_e), .illegal_e(a_illegal_e),
        .reg_write_e(a_reg_write_e), .mem_write_e(a_mem_write_e), .jump_e(a_jump_e),
        .branch_e(a_branch_e), .alu_src_a_e(a_alu_src_a_e), .alu_src_b_e(a_alu_src_b_e),
        .adder_src_e(a_adder_src_e), .res_src_e(a_res_src_e), .alu_control_e(a_alu_control_e),
        .funct3_e(a_funct3_e), .rd1_e(a_rd1_e), .rd2_e(a_rd2_e), .imm_val_e(a_imm_val_e),
        .pc_e(a_pc_e), .pc_plus4_e(a_pc_plus4_e), .rs1_e(a_rs1_e), .rs2_e(a_rs2_e), .rd_e(a_rd_e)
    );

    decode_stage_reg #(.REG_COUNT(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .valid_f(valid_f), .instr_f(instr_f), .pc_f(pc_f),
        .pc_plus4_f(pc_plus4_f), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .flush_e(flush_e), .stall_fd(b_stall_fd), .valid_e(b_valid_e), .illegal_e(b_illegal_e),
        .reg_write_e(b_reg_write_e), .mem_write_e(b_mem_write_e), .jump_e(b_jump_e),
        .branch_e(b_branch_e), .alu_src_a_e(b_alu_src_a_e), .alu_src_b_e(b_alu_src_b_e),
        .adder_src_e(b_adder_src_e), .res_src_e(b_res_src_e), .alu_control_e(b_alu_control_e),
        .funct3_e(b_funct3_e), .rd1_e(b_rd1_e), .rd2_e(b_rd2_e), .imm_val_e(b_imm_val_e),
        .pc_e(b_pc_e), .pc_plus4_e(b_pc_plus4_e), .rs1_e(b_rs1_e), .rs2_e(b_rs2_e), .rd_e(b_rd_e)
    );

    // Reference model state: architectural registers per configuration, and the E-slot summary.
    int          n_checks = 0;
    int          n_fail   = 0;
    int          reg_cnt [2] = '{32, 16};
    logic [31:0] m_reg [2][32];
    logic        m_valid;
    logic [1:0]  m_res;
    logic [4:0]  m_rd;
    logic [31:0] pc_cnt = 32'h0000_1000;

    // Kinds: 0 addi, 1 add, 2 lw, 3 sw, 4 unknown opcode (no side effects).
    localparam int K_ADDI = 0, K_ADD = 1, K_LW = 2, K_SW = 3, K_BAD = 4;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [11:0] imm);
        case (kind)
            K_ADDI:  return {imm, rs1, 3'b000, rd, 7'b0010011};
            K_ADD:   return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_LW:    return {imm, rs1, 3'b010, rd, 7'b0000011};
            K_SW:    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            default: return {imm, rs1, 3'b000, rd, 7'b0000000};
        endcase
    endfunction

    // Architectural read as seen during decode, including a writeback landing this cycle.
    function automatic logic [31:0] mread(input int c, input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= reg_cnt[c]) return 32'd0;
        if (reg_write_w && rd_w == idx) return result_w;
        return m_reg[c][idx];
    endfunction

    function automatic logic [4:0] pick_idx();
        if ($urandom_range(3) == 0) return 5'($urandom_range(31));
        return 5'($urandom_range(7));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 32; r++) m_reg[c][r] = 32'd0;
        m_valid = 1'b0;
        m_res   = 2'b00;
        m_rd    = 5'd0;
    endtask

    task automatic drive_idle();
        valid_f = 1'b0; instr_f = 32'd0; flush_e = 1'b0;
        reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'd0;
    endtask

    // One decode cycle: drive, check stall, predict the ID/EX slot, clock, compare.
    task automatic step(input logic vf, input int kind, input logic [31:0] ins, input logic fl,
                        input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                        output logic stalled);
        logic [4:0]  rs1, rs2, rd;
        logic        st, iss, rw, mw, ichk, ill16;
        logic [1:0]  res;
        logic [31:0] imm, r1 [2], r2 [2];
        @(negedge clk);
        valid_f = vf; instr_f = ins; flush_e = fl; pc_f = pc_cnt; pc_plus4_f = pc_cnt + 32'd4;
        reg_write_w = wen; rd_w = wrd; result_w = wdat;
        #1;
        rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
        st  = m_valid && m_res == 2'b01 && m_rd != 5'd0 && vf && (m_rd == rs1 || m_rd == rs2) && !fl;
        check_eq("stall32", {31'd0, a_stall_fd}, {31'd0, st});
        check_eq("stall16", {31'd0, b_stall_fd}, {31'd0, st});
        iss  = vf && !fl && !st;
        rw   = iss && (kind == K_ADDI || kind == K_ADD || kind == K_LW);
        mw   = iss && kind == K_SW;
        res  = (iss && kind == K_LW) ? 2'b01 : 2'b00;
        ichk = (kind == K_ADDI || kind == K_LW || kind == K_SW);
        imm  = (kind == K_SW) ? 32'($signed({ins[31:25], ins[11:7]})) : 32'($signed(ins[31:20]));
        ill16 = iss && (rs1[4] || rs2[4] || rd[4]);
        for (int c = 0; c < 2; c++) begin
            r1[c] = mread(c, rs1);
            r2[c] = mread(c, rs2);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++)
            if (wen && wrd != 5'd0 && int'(wrd) < reg_cnt[c]) m_reg[c][wrd] = wdat;
        m_valid = iss; m_res = res; m_rd = rd;
        if (!st) pc_cnt = pc_cnt + 32'd4;
        stalled = st;

        check_eq("valid32", {31'd0, a_valid_e}, {31'd0, iss});
        check_eq("regwr32", {31'd0, a_reg_write_e}, {31'd0, rw});
        check_eq("memwr32", {31'd0, a_mem_write_e}, {31'd0, mw});
        check_eq("ressrc32", {30'd0, a_res_src_e}, {30'd0, res});
        check_eq("illegal32", {31'd0, a_illegal_e}, 32'd0);
        check_eq("valid16", {31'd0, b_valid_e}, {31'd0, iss});
        check_eq("illegal16", {31'd0, b_illegal_e}, {31'd0, ill16});
        check_eq("memwr16", {31'd0, b_mem_write_e}, {31'd0, mw});
        if (iss) begin
            check_eq("rd_e", {27'd0, a_rd_e}, {27'd0, rd});
            check_eq("rs1_e", {27'd0, a_rs1_e}, {27'd0, rs1});
            check_eq("rs2_e", {27'd0, a_rs2_e}, {27'd0, rs2});
            check_eq("pc_e", a_pc_e, pc_f);
            check_eq("pc4_e", a_pc_plus4_e, pc_f + 32'd4);
            check_eq("rd1_32", a_rd1_e, r1[0]);
            check_eq("rd2_32", a_rd2_e, r2[0]);
            check_eq("rd1_16", b_rd1_e, r1[1]);
            check_eq("rd2_16", b_rd2_e, r2[1]);
            if (ichk) check_eq("imm_e", a_imm_val_e, imm);
        end
    endtask

    // Checks that every E-stage output of both instances sits at its reset value.
    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, {31'd0, a_valid_e | b_valid_e}, 32'd0);
        check_eq({tag, "_ctl"}, {22'd0, a_reg_write_e, a_mem_write_e, a_jump_e, a_branch_e,
                 a_alu_src_a_e, a_alu_src_b_e, a_adder_src_e, a_res_src_e, b_illegal_e}, 32'd0);
        check_eq({tag, "_alu"}, {25'd0, a_alu_control_e, a_funct3_e}, 32'd0);
        check_eq({tag, "_rd1"}, a_rd1_e | a_rd2_e | b_rd1_e, 32'd0);
        check_eq({tag, "_imm"}, a_imm_val_e | a_pc_e | a_pc_plus4_e, 32'd0);
        check_eq({tag, "_idx"}, {17'd0, a_rs1_e, a_rs2_e, a_rd_e}, 32'd0);
        check_eq({tag, "_stall"}, {31'd0, a_stall_fd | b_stall_fd}, 32'd0);
    endtask

    // Random traffic; a stalled instruction is held and re-presented like a real fetch stage would.
    task automatic random_run(input int n);
        logic        st, h_vf;
        int          h_kind;
        logic [31:0] h_ins;
        logic [4:0]  rs2;
        st = 1'b0; h_vf = 1'b0; h_kind = K_BAD; h_ins = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (!st) begin
                h_vf   = ($urandom_range(7) != 0);
                h_kind = int'($urandom_range(4));
                rs2    = pick_idx();
                h_ins  = mk(h_kind, pick_idx(), pick_idx(), rs2, {7'($urandom), rs2});
            end
            step(h_vf, h_kind, h_ins, ($urandom_range(7) == 0), 1'($urandom), pick_idx(), $urandom, st);
        end
    endtask

    initial begin
        logic st;
        rst_n = 1'b0;
        drive_idle();
        pc_f = 32'd0; pc_plus4_f = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        step(1'b1, K_ADDI, mk(K_ADDI, 5'd1, 5'd0, 5'd5, 12'd5), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("addi_imm", a_imm_val_e, 32'd5);
        check_eq("addi_rd1", a_rd1_e, 32'd0);
        // add x4,x3,x3 while writeback writes x3
        step(1'b1, K_ADD, mk(K_ADD, 5'd4, 5'd3, 5'd3, 12'd0), 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, st);
        check_eq("bypass_rd1", a_rd1_e, 32'hDEAD_BEEF);
        check_eq("bypass_rd2", a_rd2_e, 32'hDEAD_BEEF);
        // writes to x0 are discarded
        step(1'b1, K_ADD, mk(K_ADD, 5'd7, 5'd0, 5'd0, 12'd0), 1'b0, 1'b1, 5'd0, 32'h1234_5678, st);
        step(1'b1, K_ADD, mk(K_ADD, 5'd7, 5'd0, 5'd3, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("x0_zero", a_rd1_e, 32'd0);
        check_eq("x3_kept", a_rd2_e, 32'hDEAD_BEEF);
        // lw x5,0(x2); add x6,x5,x1: one bubble, then the add issues
        step(1'b1, K_LW, mk(K_LW, 5'd5, 5'd2, 5'd0, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b1, K_ADD, mk(K_ADD, 5'd6, 5'd5, 5'd1, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("lu_stall", {31'd0, st}, 32'd1);
        check_eq("lu_bubble", {31'd0, a_valid_e}, 32'd0);
        step(1'b1, K_ADD, mk(K_ADD, 5'd6, 5'd5, 5'd1, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("lu_release", {31'd0, st}, 32'd0);
        check_eq("lu_rs1", {27'd0, a_rs1_e}, 32'd5);
        check_eq("lu_issue", {31'd0, a_valid_e}, 32'd1);
        // load-use coinciding with a flush: no stall and no extra bubble afterwards
        step(1'b1, K_LW, mk(K_LW, 5'd5, 5'd2, 5'd0, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        step(1'b1, K_ADD, mk(K_ADD, 5'd6, 5'd5, 5'd1, 12'd0), 1'b1, 1'b0, 5'd0, 32'd0, st);
        check_eq("fl_stall", {31'd0, st}, 32'd0);
        check_eq("fl_valid", {31'd0, a_valid_e}, 32'd0);
        step(1'b1, K_ADD, mk(K_ADD, 5'd9, 5'd5, 5'd1, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("fl_next", {31'd0, a_valid_e}, 32'd1);
        // addi x17,x0,1 with a writeback to x17: illegal and dropped on RV32E only
        step(1'b1, K_ADDI, mk(K_ADDI, 5'd17, 5'd0, 5'd1, 12'd1), 1'b0, 1'b1, 5'd17, 32'h0000_1234, st);
        check_eq("e_illegal", {31'd0, b_illegal_e}, 32'd1);
        step(1'b1, K_ADD, mk(K_ADD, 5'd8, 5'd17, 5'd17, 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("e_x17", b_rd1_e, 32'd0);
        check_eq("i_x17", a_rd1_e, 32'h0000_1234);

        random_run(400);

        // asynchronous reset mid-stream with a live slot
        step(1'b1, K_ADDI, mk(K_ADDI, 5'd3, 5'd3, 5'd1, 12'd1), 1'b0, 1'b0, 5'd0, 32'd0, st);
        check_eq("pre_rst_valid", {31'd0, a_valid_e}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midrst");
        model_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 1; r < 32; r++)
            step(1'b1, K_ADD, mk(K_ADD, 5'd0, 5'(r), 5'(31 - r), 12'd0), 1'b0, 1'b0, 5'd0, 32'd0, st);
        random_run(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
